// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM arbitration types and widths, also imported by the acquisition scheduler.
package sdram_arbiter_pkg;

  localparam int SDRAM_ADDR_WIDTH = 21;
  localparam int SDRAM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    WAIT_RD = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// SDRAM controller command and read-return port; master is the arbiter side.
interface sdram_arbiter_if #(
  parameter int ADDR_WIDTH = sdram_arbiter_pkg::SDRAM_ADDR_WIDTH
);
  logic                  cmd_ready;
  logic                  cmd_enable;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [31:0]           cmd_data_in;
  logic [31:0]           data_out;
  logic                  data_out_ready;

  modport master (
    input  cmd_ready, data_out, data_out_ready,
    output cmd_enable, cmd_wr, cmd_address, cmd_data_in
  );

  modport slave (
    output cmd_ready, data_out, data_out_ready,
    input  cmd_enable, cmd_wr, cmd_address, cmd_data_in
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Arbitrates acquisition writes against readback reads onto one SDRAM command port,
// bounding consecutive writes while a read waits and timing out lost read data.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = SDRAM_ADDR_WIDTH,
  parameter int WR_BURST   = 8,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        aq_req,
  input  logic [ADDR_WIDTH-1:0]       aq_addr,
  input  logic [SDRAM_DATA_WIDTH-1:0] aq_data,
  output logic                        aq_ack,
  input  logic                        rd_req,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic                        rd_ack,
  output logic [SDRAM_DATA_WIDTH-1:0] rd_data,
  output logic                        rd_valid,
  output logic                        rd_timeout,
  output logic                        busy,
  sdram_arbiter_if.master             sd
);

  localparam int              WCW     = $clog2(WR_BURST + 1);
  localparam logic [WCW-1:0]  WR_MAX  = WCW'(WR_BURST);
  localparam logic [7:0]      TO_LAST = 8'(RD_TIMEOUT - 1);

  arb_state_e     state;
  logic [WCW-1:0] wr_cnt;
  logic [7:0]     to_cnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wr_cnt         <= '0;
      to_cnt         <= '0;
      aq_ack         <= 1'b0;
      rd_ack         <= 1'b0;
      rd_valid       <= 1'b0;
      rd_timeout     <= 1'b0;
      rd_data        <= '0;
      sd.cmd_enable  <= 1'b0;
      sd.cmd_wr      <= 1'b0;
      sd.cmd_address <= '0;
      sd.cmd_data_in <= '0;
    end else begin
      aq_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (!aq_req) wr_cnt <= '0;
          // A pending read only overtakes writes once the burst allowance is spent.
          if (rd_req && (!aq_req || wr_cnt == WR_MAX)) begin
            state          <= READ;
            sd.cmd_enable  <= 1'b1;
            sd.cmd_wr      <= 1'b0;
            sd.cmd_address <= rd_addr;
            sd.cmd_data_in <= '0;
          end else if (aq_req) begin
            state          <= WRITE;
            sd.cmd_enable  <= 1'b1;
            sd.cmd_wr      <= 1'b1;
            sd.cmd_address <= aq_addr;
            sd.cmd_data_in <= aq_data;
          end
        end
        WRITE: begin
          if (sd.cmd_ready) begin
            sd.cmd_enable <= 1'b0;
            aq_ack        <= 1'b1;
            state         <= IDLE;
            if (wr_cnt != WR_MAX) wr_cnt <= wr_cnt + 1'b1;
          end
        end
        READ: begin
          if (sd.cmd_ready) begin
            sd.cmd_enable <= 1'b0;
            rd_ack        <= 1'b1;
            wr_cnt        <= '0;
            to_cnt        <= '0;
            state         <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // Returned data beats a timeout landing on the same cycle.
          if (sd.data_out_ready) begin
            rd_data  <= sd.data_out;
            rd_valid <= 1'b1;
            state    <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            rd_timeout <= 1'b1;
            state      <= IDLE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 21, SDRAM command word-address width.
REQ-002 Parameter WR_BURST, default 8, maximum consecutive writes granted while a read is pending.
REQ-003 Parameter RD_TIMEOUT, default 255, maximum cycles to wait for read data.
REQ-004 clk  input  1  system clock (6x receiver clock domain); one clock only.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 aq_req  input  1  acquisition write request; aq_addr  input  ADDR_WIDTH  write address; aq_data  input  32  write data.
REQ-007 aq_ack  output  1  one-cycle pulse when the write command is accepted by the controller.
REQ-008 rd_req  input  1  readback request; rd_addr  input  ADDR_WIDTH  read address.
REQ-009 rd_ack  output  1  one-cycle pulse when the read command is accepted.
REQ-010 rd_data  output  32  read data; rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-011 rd_timeout  output  1  one-cycle pulse when read data fails to return within RD_TIMEOUT cycles.
REQ-012 cmd_ready  input  1; cmd_enable  output  1; cmd_wr  output  1; cmd_address  output  ADDR_WIDTH; cmd_data_in  output  32: SDRAM controller command port.
REQ-013 data_out  input  32; data_out_ready  input  1: SDRAM controller read-return port.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 States SHALL be IDLE, WRITE, READ, WAIT_RD.
REQ-016 IDLE: if rd_req and (not aq_req, or write count = WR_BURST) -> READ; else if aq_req -> WRITE; else stay.
REQ-017 Write count SHALL increment (saturating at WR_BURST) on each accepted write, and SHALL clear on an accepted read or on any IDLE cycle with no aq_req.
REQ-018 On entering WRITE/READ, cmd_address, cmd_data_in, cmd_wr SHALL be registered from the selected requester, and cmd_enable SHALL be asserted.
REQ-019 cmd_enable, cmd_address, cmd_data_in, cmd_wr SHALL be held stable until the cycle where cmd_enable and cmd_ready are both high; cmd_enable SHALL be low the following cycle.
REQ-020 On write acceptance, aq_ack SHALL pulse the following cycle, and the FSM SHALL return to IDLE.
REQ-021 On read acceptance, rd_ack SHALL pulse the following cycle, and the FSM SHALL go to WAIT_RD.
REQ-022 WAIT_RD: on data_out_ready, rd_data <= data_out, rd_valid pulses the next cycle, -> IDLE.
REQ-023 WAIT_RD: an 8-bit cycle counter SHALL start at 0; on reaching RD_TIMEOUT without data_out_ready, rd_timeout SHALL pulse and the FSM SHALL go to IDLE.
REQ-024 data_out_ready outside WAIT_RD SHALL be ignored.
REQ-025 Requesters SHALL hold req/addr/data until ack; a request withdrawn before acceptance is still completed once the command has been issued.
REQ-026 Only one outstanding command at any time; minimum one IDLE cycle between commands.
REQ-027 Simultaneous aq_req and rd_req with write count below WR_BURST: write wins.

Reset
REQ-028 While rst is high: state IDLE; all outputs 0; counters 0; rd_data 0.
REQ-029 Reset mid-command SHALL drop cmd_enable immediately (asynchronously) and SHALL produce no ack, valid or timeout pulse.

Structure
REQ-030 State encodings and the SDRAM address-width constants SHALL live in a shared package/include used with the acquisition scheduler.
REQ-031 The implementation SHALL be a single module with no sub-modules.

Verification
REQ-032 Single write: aq_req=1, aq_addr=0x000010, aq_data=0x00ABCDEF, cmd_ready high -> cmd_enable high 1 cycle with cmd_wr=1, cmd_address 0x000010, then aq_ack pulse.
REQ-033 Held ready: cmd_ready low for 5 cycles -> cmd_enable and cmd_address stable for 5 cycles, with acceptance on cycle 6.
REQ-034 Fairness: aq_req continuously high and rd_req high -> exactly 8 writes, then 1 read, then writes resume.
REQ-035 Read return: read at 0x000020, data_out_ready after 3 cycles with data_out=0x12345678 -> rd_valid pulse with rd_data 0x12345678, then IDLE.
REQ-036 Timeout: read accepted, no data_out_ready -> rd_timeout pulse at cycle 255 of WAIT_RD, with rd_valid never asserted.
REQ-037 Reset mid-WAIT_RD -> all outputs 0 immediately; a later data_out_ready produces no rd_valid.
